control_unit: RTL
=================

# control_unit

Fetch/decode/execute sequencer for the 8-bit `datapath`. It drives every datapath control strobe and the external memory read/write handshake. It decodes the opcode byte held in `ir_out[15:8]` and uses `latch_flags` for conditional jumps. It sits beside `datapath` in the CPU top level, and one instruction completes every 2–5 cycles when memory has zero wait states.

## Interface
- `HALT_ON_ILLEGAL`, default 0: 0 = undefined opcode executes as NOP; 1 = undefined opcode enters HALT.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `ir_out`  in  16  from datapath; `[15:8]` opcode, `[7:0]` ALU-op byte.
- `latch_flags`  in  3  `{N,C,Z}`, bit0 = Z, bit1 = C, bit2 = N.
- `mem_ready`  in  1  memory completes the current read or write this cycle.
- `pc_inc`, `pc_load`  out  1  PC increment / load from jump register.
- `reg_load`, `reg_enable`  out  1  register file write from databus / drive databus.
- `reg_in_regselect`, `reg_out_regselect`, `reg_alu_regselect`  out  2  register selects.
- `alu_operation`  out  4  ALU function.
- `latch_grab`, `latch_store`  out  1  capture ALU result and flags / drive result onto databus.
- `mar_high`, `mar_low`, `ir_high`, `ir_low`, `jr_high`, `jr_low`  out  1  byte-load strobes from databus.
- `mem_rd`, `mem_wr`  out  1  memory request, held asserted until `mem_ready`.
- `addr_sel`  out  1  0 = address from `pc_out`, 1 = address from `mar_out`.
- `halted`  out  1  high while in HALT.

## Operation
- Opcode byte fields: `[7:4]` class, `[3:2]` rd, `[1:0]` rs (also the flag index for Jcc).
- Classes:
  - 0 NOP
  - 1 MOV rd,rs
  - 2 LDI rd,#imm8
  - 3 ALU rd,rs,op8
  - 4 LD rd,[a16]
  - 5 ST [a16],rs
  - 6 JMP a16
  - 7 Jcc a16
  - F HLT
  - 8–E undefined
- States: FETCH, DECODE, OPND1, OPND2, EXEC1, EXEC2, HALT. Reset enters FETCH.
- A memory state (FETCH, OPND1, OPND2, LD/ST EXEC1) holds `mem_rd` or `mem_wr` and waits while `mem_ready`=0. The destination strobe, plus `pc_inc` when reading at PC, is asserted only in the cycle `mem_ready`=1, and the state advances on that edge.
- FETCH: `mem_rd`, `addr_sel`=0; on ready assert `ir_high` and `pc_inc` → DECODE.
- DECODE: no strobes. Branch on class:
  - NOP → FETCH
  - MOV → EXEC1
  - LDI, ALU, LD, ST, JMP, Jcc → OPND1
  - HLT → HALT
  - undefined → FETCH, or HALT if `HALT_ON_ILLEGAL`=1
- OPND1, on ready, with `pc_inc`:
  - LDI: `reg_load`, `reg_in_regselect`=rd → FETCH.
  - ALU: `ir_low` → EXEC1.
  - LD/ST: `mar_high` → OPND2.
  - JMP/Jcc: `jr_high` → OPND2.
- OPND2, on ready, with `pc_inc`: `mar_low` (LD/ST) or `jr_low` (JMP/Jcc) → EXEC1.
- EXEC1:
  - MOV: `reg_enable` with `reg_out_regselect`=rs; `reg_load` with `reg_in_regselect`=rd → FETCH.
  - ALU: `alu_operation`=`ir_out[3:0]`, `reg_alu_regselect`=rs, `reg_enable` with `reg_out_regselect`=rd, `latch_grab` → EXEC2.
  - LD: `mem_rd`, `addr_sel`=1; on ready `reg_load` into rd → FETCH.
  - ST: `mem_wr`, `addr_sel`=1, `reg_enable` with `reg_out_regselect`=rs; on ready → FETCH.
  - JMP: `pc_load` → FETCH.
  - Jcc: `pc_load` only if `latch_flags[rs]`=1 (rs=3 never taken) → FETCH.
- EXEC2 (ALU only): `alu_operation` held, `latch_store`, `reg_load` into rd → FETCH.
- HALT: all strobes 0, `halted`=1. Exit only via reset.
- Invariants:
  - At most one databus driver per cycle: memory read data, `reg_enable`, or `latch_store`.
  - `pc_inc` and `pc_load` are never asserted together.
  - `mem_rd` and `mem_wr` are never asserted together.

## Timing
- Outputs are a function of the registered state, the registered opcode and `mem_ready`. The only combinational input paths are `mem_ready` → strobes and `latch_flags` → `pc_load`.
- `ir_out[15:8]` is valid in DECODE, because it was loaded at the FETCH edge.
- Reset asserted: state = FETCH immediately. All outputs are 0 except the FETCH request, and `mem_rd` is gated low while reset is asserted.
- Reset asserted mid-instruction: the instruction is abandoned and no partial strobe is emitted.
- Reset release: the first `mem_rd` appears in the cycle after release.
- Zero-wait instruction lengths: NOP 2, MOV 3, LDI 3, ALU 5, LD 5, ST 5, JMP 5, Jcc 5 cycles (taken or not).
- Each cycle with `mem_ready`=0 adds exactly one cycle.
- Undefined state encodings recover to FETCH.

## Structure
- `cpu_pkg` holds:
  - the opcode class localparams;
  - the state encoding;
  - the flag bit indices (Z=0, C=1, N=2);
  - the `addr_sel` encodings.
- Sub-module `control_decode`: combinational opcode → class, rd, rs and flag-select decode, shared with the disassembler and monitor.

## Test plan
- Reset asserted during ALU EXEC1 → all strobes 0 at once. After release, the next edge sees `mem_rd`=1 and `addr_sel`=0.
- NOP (0x00) followed by MOV r2,r1 (0x19), `mem_ready`=1 → `ir_high` and `pc_inc` at cycles 0 and 2. MOV EXEC1 at cycle 4 shows `reg_out_regselect`=1, `reg_in_regselect`=2, `reg_load`=1.
- ALU (0x36) with op byte 0x05 → `ir_low` in OPND1; EXEC1 shows `alu_operation`=5, `reg_alu_regselect`=2, `reg_out_regselect`=1, `latch_grab`; EXEC2 shows `latch_store` plus `reg_load` to r1. Total 5 cycles.
- ST (0x52) with `mem_ready` low for 3 cycles in EXEC1 → `mem_wr` and `addr_sel`=1 held 4 cycles, with `reg_enable` and `reg_out_regselect`=2. Total 8 cycles.
- Jcc Z (0x70) with Z=1 → `pc_load`=1 in EXEC1. Same opcode with Z=0 → no `pc_load`; exactly 3 `pc_inc` across the instruction.
- HLT (0xF0) → `halted`=1 and no further `mem_rd`. Opcode 0x80 with `HALT_ON_ILLEGAL`=0 → back to FETCH after DECODE; with `HALT_ON_ILLEGAL`=1 → `halted`=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: opcode classes, sequencer
// state encoding, flag bit indices, address-mux encodings and the strobe bundle.
package cpu_pkg;

  // Opcode class, taken from opcode bits [7:4]. Classes 8..E are undefined.
  localparam logic [3:0] CLS_NOP = 4'h0;
  localparam logic [3:0] CLS_MOV = 4'h1;
  localparam logic [3:0] CLS_LDI = 4'h2;
  localparam logic [3:0] CLS_ALU = 4'h3;
  localparam logic [3:0] CLS_LD  = 4'h4;
  localparam logic [3:0] CLS_ST  = 4'h5;
  localparam logic [3:0] CLS_JMP = 4'h6;
  localparam logic [3:0] CLS_JCC = 4'h7;
  localparam logic [3:0] CLS_HLT = 4'hF;

  // Sequencer states; the eighth encoding is unused and recovers to FETCH.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_OPND1  = 3'd2,
    ST_OPND2  = 3'd3,
    ST_EXEC1  = 3'd4,
    ST_EXEC2  = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  // Bit positions inside latch_flags {N,C,Z}; a Jcc rs field of 3 selects none.
  localparam logic [1:0] FLAG_Z = 2'd0;
  localparam logic [1:0] FLAG_C = 2'd1;
  localparam logic [1:0] FLAG_N = 2'd2;

  // Memory address source.
  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_MAR = 1'b1;

  // Every strobe the sequencer drives, bundled so it can be cleared in one go.
  typedef struct packed {
    logic       pc_inc;
    logic       pc_load;
    logic       reg_load;
    logic       reg_enable;
    logic [1:0] reg_in_regselect;
    logic [1:0] reg_out_regselect;
    logic [1:0] reg_alu_regselect;
    logic [3:0] alu_operation;
    logic       latch_grab;
    logic       latch_store;
    logic       mar_high;
    logic       mar_low;
    logic       ir_high;
    logic       ir_low;
    logic       jr_high;
    logic       jr_low;
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_sel;
    logic       halted;
  } ctrl_t;

  // True for the classes the sequencer knows how to execute.
  function automatic logic class_defined(input logic [3:0] cls);
    return (cls <= CLS_JCC) || (cls == CLS_HLT);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational opcode field decode, shared with the disassembler and monitor.
module control_decode
  import cpu_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [3:0] op_class,
  output logic [1:0] rd,
  output logic [1:0] rs,
  output logic [1:0] flag_sel,
  output logic       flag_valid,
  output logic       defined
);

  assign op_class   = opcode[7:4];
  assign rd         = opcode[3:2];
  assign rs         = opcode[1:0];
  // Jcc reuses the rs field as the flag index; index 3 names no flag.
  assign flag_sel   = opcode[1:0];
  assign flag_valid = (opcode[1:0] != 2'd3);
  assign defined    = class_defined(opcode[7:4]);

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit datapath.
module control_unit
  import cpu_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] ir_out,
  input  logic [2:0]  latch_flags,
  input  logic        mem_ready,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        reg_load,
  output logic        reg_enable,
  output logic [1:0]  reg_in_regselect,
  output logic [1:0]  reg_out_regselect,
  output logic [1:0]  reg_alu_regselect,
  output logic [3:0]  alu_operation,
  output logic        latch_grab,
  output logic        latch_store,
  output logic        mar_high,
  output logic        mar_low,
  output logic        ir_high,
  output logic        ir_low,
  output logic        jr_high,
  output logic        jr_low,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        addr_sel,
  output logic        halted
);

  state_t     state, state_next;
  ctrl_t      ctrl, ctrl_out;
  logic [3:0] op_class;
  logic [1:0] rd, rs, flag_sel;
  logic       flag_valid, op_defined, jcc_take;
  logic       unused_op_hi;

  // The sequencer only interprets the low nibble of the ALU-op byte.
  assign unused_op_hi = ^ir_out[7:4];

  control_decode u_decode (
    .opcode     (ir_out[15:8]),
    .op_class   (op_class),
    .rd         (rd),
    .rs         (rs),
    .flag_sel   (flag_sel),
    .flag_valid (flag_valid),
    .defined    (op_defined)
  );

  // Select the flag tested by a conditional jump.
  always_comb begin
    jcc_take = 1'b0;
    if (flag_valid) begin
      case (flag_sel)
        FLAG_Z:  jcc_take = latch_flags[FLAG_Z];
        FLAG_C:  jcc_take = latch_flags[FLAG_C];
        FLAG_N:  jcc_take = latch_flags[FLAG_N];
        default: jcc_take = 1'b0;
      endcase
    end
  end

  // State register; reset abandons any instruction and restarts at FETCH.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_FETCH;
    else        state <= state_next;
  end

  // Next-state and strobe generation from state, opcode and mem_ready.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    ctrl       = '0;
    state_next = state;
    case (state)
      ST_FETCH: begin
        ctrl.mem_rd   = 1'b1;
        ctrl.addr_sel = ADDR_PC;
        if (mem_ready) begin
          ctrl.ir_high = 1'b1;
          ctrl.pc_inc  = 1'b1;
          state_next   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!op_defined) begin
          state_next = HALT_ON_ILLEGAL ? ST_HALT : ST_FETCH;
        end else begin
          case (op_class)
            CLS_NOP: state_next = ST_FETCH;
            CLS_MOV: state_next = ST_EXEC1;
            CLS_HLT: state_next = ST_HALT;
            default: state_next = ST_OPND1;
          endcase
        end
      end
      ST_OPND1: begin
        ctrl.mem_rd   = 1'b1;
        ctrl.addr_sel = ADDR_PC;
        if (mem_ready) begin
          ctrl.pc_inc = 1'b1;
          case (op_class)
            CLS_LDI: begin
              ctrl.reg_load         = 1'b1;
              ctrl.reg_in_regselect = rd;
              state_next            = ST_FETCH;
            end
            CLS_ALU: begin
              ctrl.ir_low = 1'b1;
              state_next  = ST_EXEC1;
            end
            CLS_LD, CLS_ST: begin
              ctrl.mar_high = 1'b1;
              state_next    = ST_OPND2;
            end
            CLS_JMP, CLS_JCC: begin
              ctrl.jr_high = 1'b1;
              state_next   = ST_OPND2;
            end
            default: state_next = ST_FETCH;
          endcase
        end
      end
      ST_OPND2: begin
        ctrl.mem_rd   = 1'b1;
        ctrl.addr_sel = ADDR_PC;
        if (mem_ready) begin
          ctrl.pc_inc  = 1'b1;
          ctrl.mar_low = (op_class == CLS_LD) || (op_class == CLS_ST);
          ctrl.jr_low  = (op_class == CLS_JMP) || (op_class == CLS_JCC);
          state_next   = ST_EXEC1;
        end
      end
      ST_EXEC1: begin
        state_next = ST_FETCH;
        case (op_class)
          CLS_MOV: begin
            ctrl.reg_enable        = 1'b1;
            ctrl.reg_out_regselect = rs;
            ctrl.reg_load          = 1'b1;
            ctrl.reg_in_regselect  = rd;
          end
          CLS_ALU: begin
            ctrl.alu_operation     = ir_out[3:0];
            ctrl.reg_alu_regselect = rs;
            ctrl.reg_enable        = 1'b1;
            ctrl.reg_out_regselect = rd;
            ctrl.latch_grab        = 1'b1;
            state_next             = ST_EXEC2;
          end
          CLS_LD: begin
            ctrl.mem_rd           = 1'b1;
            ctrl.addr_sel         = ADDR_MAR;
            ctrl.reg_in_regselect = rd;
            ctrl.reg_load         = mem_ready;
            if (!mem_ready) state_next = ST_EXEC1;
          end
          CLS_ST: begin
            ctrl.mem_wr            = 1'b1;
            ctrl.addr_sel          = ADDR_MAR;
            ctrl.reg_enable        = 1'b1;
            ctrl.reg_out_regselect = rs;
            if (!mem_ready) state_next = ST_EXEC1;
          end
          CLS_JMP: ctrl.pc_load = 1'b1;
          CLS_JCC: ctrl.pc_load = jcc_take;
          default: ;
        endcase
      end
      ST_EXEC2: begin
        ctrl.alu_operation    = ir_out[3:0];
        ctrl.latch_store      = 1'b1;
        ctrl.reg_load         = 1'b1;
        ctrl.reg_in_regselect = rd;
        state_next            = ST_FETCH;
      end
      ST_HALT: ctrl.halted = 1'b1;
      default: state_next = ST_FETCH;
    endcase
  end

  // While reset is held every strobe, including the FETCH read, is forced low.
  assign ctrl_out = reset ? ctrl : '0;

  assign pc_inc            = ctrl_out.pc_inc;
  assign pc_load           = ctrl_out.pc_load;
  assign reg_load          = ctrl_out.reg_load;
  assign reg_enable        = ctrl_out.reg_enable;
  assign reg_in_regselect  = ctrl_out.reg_in_regselect;
  assign reg_out_regselect = ctrl_out.reg_out_regselect;
  assign reg_alu_regselect = ctrl_out.reg_alu_regselect;
  assign alu_operation     = ctrl_out.alu_operation;
  assign latch_grab        = ctrl_out.latch_grab;
  assign latch_store       = ctrl_out.latch_store;
  assign mar_high          = ctrl_out.mar_high;
  assign mar_low           = ctrl_out.mar_low;
  assign ir_high           = ctrl_out.ir_high;
  assign ir_low            = ctrl_out.ir_low;
  assign jr_high           = ctrl_out.jr_high;
  assign jr_low            = ctrl_out.jr_low;
  assign mem_rd            = ctrl_out.mem_rd;
  assign mem_wr            = ctrl_out.mem_wr;
  assign addr_sel          = ctrl_out.addr_sel;
  assign halted            = ctrl_out.halted;

endmodule
